// File: rtl/tx_seq_pkg.sv
// Shared types and constants for the TX packet sequencer.
package tx_seq_pkg;

    localparam int unsigned MAX_BYTES_DEFAULT = 64;
    localparam int unsigned PID_W             = 4;

    localparam logic [PID_W-1:0] PID_NONE  = 4'b0000;
    localparam logic [PID_W-1:0] PID_OUT   = 4'b0001;
    localparam logic [PID_W-1:0] PID_IN    = 4'b1001;
    localparam logic [PID_W-1:0] PID_ACK   = 4'b0010;
    localparam logic [PID_W-1:0] PID_NAK   = 4'b1010;
    localparam logic [PID_W-1:0] PID_STALL = 4'b1110;
    localparam logic [PID_W-1:0] PID_DATA  = 4'b0011;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        PID  = 3'd2,
        DATA = 3'd3,
        CRC1 = 3'd4,
        CRC2 = 3'd5,
        EOP  = 3'd6
    } state_t;

    // True for the packet codes the sequencer knows how to send.
    function automatic logic is_valid_pid(input logic [PID_W-1:0] code);
        case (code)
            PID_OUT, PID_IN, PID_ACK, PID_NAK, PID_STALL, PID_DATA: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tx_byte_counter.sv
// Payload byte counter: clear has priority, saturates at MAX.
module tx_byte_counter
    import tx_seq_pkg::*;
#(
    parameter int unsigned MAX = MAX_BYTES_DEFAULT,
    parameter int unsigned W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         at_max_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign at_max_c = (count_q == W'(MAX));
    assign count    = count_q;

    // Next count: clear, else increment unless already at the payload limit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !at_max_c) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tx_packet_sequencer.sv
// TX packet sequencer: walks SYNC, PID, optional DATA/CRC bytes and EOP.
// Optional build macro TX_EMPTY_DATA_ERR_EN: a DATA request with an empty
// buffer raises tx_error after PID and skips straight to EOP (no CRC).
module tx_packet_sequencer
    import tx_seq_pkg::*;
#(
    parameter int unsigned MAX_BYTES = MAX_BYTES_DEFAULT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [3:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic       byte_done,
    input  logic       eop_done,
    output logic       sync_start,
    output logic       pid_start,
    output logic       crc_start,
    output logic [3:0] tx_packet_q,
    output logic       load_byte,
    output logic       get_tx_packet_data,
    output logic       eop_start,
    output logic       tx_transfer_active,
    output logic       tx_error
);

    localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);

    state_t             state_q, state_d;
    logic [PID_W-1:0]   pkt_q, pkt_d;
    logic               load_q, load_d;
    logic               pop_q, pop_d;
    logic               err_q, err_d;
    logic               sync_q, sync_d;
    logic               pid_q, pid_d;
    logic               crc_q, crc_d;
    logic               eop_q, eop_d;
    logic               active_q, active_d;

    logic [CNT_W-1:0]   cnt_count;
    logic               cnt_at_max_c;
    logic               cnt_clr_c;
    logic               data_more_c;

    tx_byte_counter #(
        .MAX (MAX_BYTES),
        .W   (CNT_W)
    ) u_byte_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (cnt_clr_c),
        .enable   (pop_d),
        .count    (cnt_count),
        .at_max_c (cnt_at_max_c)
    );

    // Another payload byte may be sent only if the buffer has one and the limit is not hit.
    assign data_more_c = (buffer_occupancy != 7'd0) && !cnt_at_max_c;

    // Next state, byte load/pop strobes and decoded output levels for the next cycle.
    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        load_d    = 1'b0;
        pop_d     = 1'b0;
        err_d     = 1'b0;
        // Clear on packet end; also scrub in IDLE so no stale count reaches the next packet.
        cnt_clr_c = (state_q == IDLE) && (cnt_count != '0);

        case (state_q)
            IDLE: begin
                if (tx_packet != PID_NONE) begin
                    if (is_valid_pid(tx_packet)) begin
                        state_d = SYNC;
                        pkt_d   = tx_packet;
                        load_d  = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            SYNC: begin
                if (byte_done) begin
                    state_d = PID;
                    load_d  = 1'b1;
                end
            end
            PID: begin
                if (byte_done) begin
                    if (pkt_q != PID_DATA) begin
                        state_d = EOP;
                    end else if (buffer_occupancy != 7'd0) begin
                        state_d = DATA;
                        load_d  = 1'b1;
                        pop_d   = 1'b1;
                    end else begin
`ifdef TX_EMPTY_DATA_ERR_EN
                        state_d = EOP;
                        err_d   = 1'b1;
`else
                        state_d = CRC1;
                        load_d  = 1'b1;
`endif
                    end
                end
            end
            DATA: begin
                if (byte_done) begin
                    if (data_more_c) begin
                        load_d  = 1'b1;
                        pop_d   = 1'b1;
                    end else begin
                        state_d = CRC1;
                        load_d  = 1'b1;
                    end
                end
            end
            CRC1: begin
                if (byte_done) begin
                    state_d = CRC2;
                    load_d  = 1'b1;
                end
            end
            CRC2: begin
                if (byte_done) begin
                    state_d = EOP;
                end
            end
            EOP: begin
                if (eop_done) begin
                    state_d   = IDLE;
                    cnt_clr_c = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sync_d   = (state_d == SYNC);
        pid_d    = (state_d == PID);
        crc_d    = (state_d == CRC1) || (state_d == CRC2);
        eop_d    = (state_d == EOP);
        active_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            pkt_q    <= PID_NONE;
            load_q   <= 1'b0;
            pop_q    <= 1'b0;
            err_q    <= 1'b0;
            sync_q   <= 1'b0;
            pid_q    <= 1'b0;
            crc_q    <= 1'b0;
            eop_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pkt_q    <= pkt_d;
            load_q   <= load_d;
            pop_q    <= pop_d;
            err_q    <= err_d;
            sync_q   <= sync_d;
            pid_q    <= pid_d;
            crc_q    <= crc_d;
            eop_q    <= eop_d;
            active_q <= active_d;
        end
    end

    assign sync_start         = sync_q;
    assign pid_start          = pid_q;
    assign crc_start          = crc_q;
    assign tx_packet_q        = pkt_q;
    assign load_byte          = load_q;
    assign get_tx_packet_data = pop_q;
    assign eop_start          = eop_q;
    assign tx_transfer_active = active_q;
    assign tx_error           = err_q;

endmodule

// File: tb/tb_tx_packet_sequencer.sv
// Randomized bench for tx_packet_sequencer against a per-packet byte-sequence model.
module tb_tx_packet_sequencer;

    localparam logic [3:0] C_OUT   = 4'b0001;
    localparam logic [3:0] C_IN    = 4'b1001;
    localparam logic [3:0] C_ACK   = 4'b0010;
    localparam logic [3:0] C_NAK   = 4'b1010;
    localparam logic [3:0] C_STALL = 4'b1110;
    localparam logic [3:0] C_DATA  = 4'b0011;
    localparam int MAXB = 64;

    localparam int TK_S = 1;
    localparam int TK_P = 2;
    localparam int TK_D = 3;
    localparam int TK_C = 4;
    localparam int TK_BAD = 9;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [3:0] tx_packet;
    logic [6:0] buffer_occupancy;
    logic       byte_done;
    logic       eop_done;
    logic       sync_start, pid_start, crc_start;
    logic [3:0] tx_packet_q;
    logic       load_byte, get_tx_packet_data, eop_start, tx_transfer_active, tx_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ctl_outs;
    assign ctl_outs = {sync_start, pid_start, crc_start, load_byte,
                       get_tx_packet_data, eop_start, tx_transfer_active, tx_error};

    tx_packet_sequencer dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_packet          (tx_packet),
        .buffer_occupancy   (buffer_occupancy),
        .byte_done          (byte_done),
        .eop_done           (eop_done),
        .sync_start         (sync_start),
        .pid_start          (pid_start),
        .crc_start          (crc_start),
        .tx_packet_q        (tx_packet_q),
        .load_byte          (load_byte),
        .get_tx_packet_data (get_tx_packet_data),
        .eop_start          (eop_start),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_valid_code(input logic [3:0] c);
        return (c == C_OUT) || (c == C_IN) || (c == C_ACK) ||
               (c == C_NAK) || (c == C_STALL) || (c == C_DATA);
    endfunction

    function automatic logic [3:0] rand_invalid();
        logic [3:0] c;
        do c = 4'($urandom_range(1, 15)); while (is_valid_code(c));
        return c;
    endfunction

    function automatic logic [3:0] rand_valid();
        case ($urandom_range(0, 5))
            0:       return C_OUT;
            1:       return C_IN;
            2:       return C_ACK;
            3:       return C_NAK;
            4:       return C_STALL;
            default: return C_DATA;
        endcase
    endfunction

    // Which byte the selector is told to send on a load_byte cycle.
    function automatic int classify();
        if (sync_start && !pid_start && !crc_start && !get_tx_packet_data) return TK_S;
        if (!sync_start && pid_start && !crc_start && !get_tx_packet_data) return TK_P;
        if (!sync_start && !pid_start && !crc_start && get_tx_packet_data) return TK_D;
        if (!sync_start && !pid_start && crc_start && !get_tx_packet_data) return TK_C;
        return TK_BAD;
    endfunction

    // Issue one valid request from IDLE, emulate shifter/buffer/line encoder, compare with model.
    task automatic run_packet(input logic [3:0] code, input int occ, input bit noise, input bit hold);
        int exp_q[$];
        int obs_q[$];
        int exp_pops, exp_errs, pops, errs, rem, eop_wait, first_bad, n_data, occ_left;
        bit in_byte, eop_seen, pq_bad, done;
        exp_pops = 0; exp_errs = 0; pops = 0; errs = 0; rem = 0; eop_wait = 0;
        first_bad = -1; in_byte = 0; eop_seen = 0; pq_bad = 0; done = 0;
        occ_left = occ;

        exp_q.push_back(TK_S);
        exp_q.push_back(TK_P);
        if (code == C_DATA) begin
            n_data   = (occ < MAXB) ? occ : MAXB;
            exp_pops = n_data;
            if (occ == 0) begin
`ifdef TX_EMPTY_DATA_ERR_EN
                exp_errs = 1;
`else
                exp_q.push_back(TK_C);
                exp_q.push_back(TK_C);
`endif
            end else begin
                repeat (n_data) exp_q.push_back(TK_D);
                exp_q.push_back(TK_C);
                exp_q.push_back(TK_C);
            end
        end

        buffer_occupancy = 7'(occ);
        tx_packet = code;
        byte_done = 1'b0;
        eop_done  = 1'b0;
        @(negedge clk);
        check_eq("start_latency", 32'({tx_transfer_active, sync_start, load_byte}), 32'h7);
        check_eq("pkt_capture", 32'(tx_packet_q), 32'(code));

        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!tx_transfer_active) begin
                done = 1;
                check_eq("idle_outs", 32'(ctl_outs), 32'h0);
                tx_packet = hold ? code : 4'h0;
                byte_done = 1'b0;
                eop_done  = 1'b0;
                break;
            end
            tx_packet = hold ? code : (noise ? 4'($urandom_range(0, 15)) : 4'h0);
            byte_done = 1'b0;
            eop_done  = 1'b0;
            if (tx_packet_q != code) pq_bad = 1;
            if (tx_error) errs++;
            if (get_tx_packet_data) begin
                pops++;
                if (occ_left > 0) occ_left--;
                buffer_occupancy = 7'(occ_left);
            end
            if (load_byte) begin
                obs_q.push_back(classify());
                in_byte = 1;
                rem = int'($urandom_range(1, 3));
            end else if (in_byte) begin
                rem--;
                if (rem == 0) begin
                    byte_done = 1'b1;
                    in_byte   = 0;
                end
            end else if (get_tx_packet_data) begin
                obs_q.push_back(TK_BAD);
            end
            if (eop_start) begin
                eop_seen = 1;
                in_byte  = 0;
                if (eop_wait == 0) eop_wait = int'($urandom_range(1, 3));
                eop_wait--;
                if (eop_wait == 0) eop_done = 1'b1;
                else if (noise) byte_done = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end

        if (!done) begin
            tx_packet = 4'h0;
            byte_done = 1'b0;
            eop_done  = 1'b0;
        end
        check_eq("complete", 32'(done), 32'h1);
        check_eq("seq_len", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (first_bad < 0 && (i >= obs_q.size() || obs_q[i] != exp_q[i])) first_bad = i;
        end
        check_eq("seq_order", 32'(first_bad), 32'hFFFF_FFFF);
        check_eq("pops", 32'(pops), 32'(exp_pops));
        check_eq("errors", 32'(errs), 32'(exp_errs));
        check_eq("eop_seen", 32'(eop_seen), 32'h1);
        check_eq("pkt_q_stable", 32'(pq_bad), 32'h0);
    endtask

    // Invalid code in IDLE: single error pulse, no activity.
    task automatic run_invalid(input logic [3:0] code);
        tx_packet = code;
        byte_done = 1'b1;
        @(negedge clk);
        check_eq("inv_err", 32'({tx_error, tx_transfer_active, load_byte}), 32'h4);
        tx_packet = 4'h0;
        byte_done = 1'b0;
        @(negedge clk);
        check_eq("inv_err_1cyc", 32'({tx_error, tx_transfer_active}), 32'h0);
    endtask

    // Assert reset while the second payload byte is loaded.
    task automatic run_reset_mid_data();
        int pops = 0;
        int extra = 0;
        bit hit = 0;
        buffer_occupancy = 7'd10;
        tx_packet = C_DATA;
        byte_done = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            tx_packet = 4'h0;
            if (get_tx_packet_data) pops++;
            if (pops == 2) hit = 1;
            byte_done = hit ? 1'b1 : !load_byte;
        end
        check_eq("rst_reach_byte2", 32'(hit), 32'h1);
        #2;
        n_rst = 1'b0;
        #1;
        check_eq("rst_async_outs", 32'({ctl_outs, tx_packet_q}), 32'h0);
        repeat (2) @(negedge clk);
        check_eq("rst_held_outs", 32'({ctl_outs, tx_packet_q}), 32'h0);
        n_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (get_tx_packet_data || load_byte || tx_transfer_active) extra++;
        end
        byte_done = 1'b0;
        check_eq("rst_then_idle", 32'(extra), 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [3:0] code;
        int occ;
        n_rst = 1'b0;
        tx_packet = C_ACK;
        buffer_occupancy = 7'd0;
        byte_done = 1'b1;
        eop_done = 1'b0;
        #1;
        check_eq("reset_outs", 32'({ctl_outs, tx_packet_q}), 32'h0);
        repeat (3) @(negedge clk);
        check_eq("reset_hold", 32'({ctl_outs, tx_packet_q}), 32'h0);
        tx_packet = 4'h0;
        byte_done = 1'b0;
        n_rst = 1'b1;
        @(negedge clk);
        check_eq("idle_after_reset", 32'(tx_transfer_active), 32'h0);

        run_packet(C_ACK, 0, 1'b0, 1'b0);
        run_packet(C_DATA, 3, 1'b0, 1'b0);
        run_packet(C_DATA, 100, 1'b0, 1'b0);
        run_packet(C_DATA, 64, 1'b1, 1'b0);
        run_packet(C_DATA, 0, 1'b0, 1'b0);
        run_invalid(4'b0101);
        run_reset_mid_data();
        run_packet(C_STALL, 5, 1'b1, 1'b0);
        run_packet(C_ACK, 0, 1'b0, 1'b1);
        run_packet(C_ACK, 0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                run_invalid(rand_invalid());
            end else begin
                code = (r < 5) ? C_DATA : rand_valid();
                occ = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 127))
                                                  : int'($urandom_range(0, 8));
                run_packet(code, occ, 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
